// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity receiver and related parity blocks.
package parity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } rx_state_e;

  localparam int DATA_W_DEF = 4;
  localparam int ERR_CNT_W  = 8;

endpackage

// File: rtl/parity_reduce.sv
// XOR reduction of a data word; 1 means an odd number of ones.
module parity_reduce #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_o
);

  assign parity_o = ^data_i;

endmodule

// File: rtl/parity_check_rx.sv
// Serial frame receiver: DATA_W data bits MSB first, then one parity bit.
// Reports the captured word, parity mismatch and a saturating error count.
module parity_check_rx
  import parity_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [DATA_W-1:0]      dout_q, dout_d;
  logic                   dv_q, dv_d;
  logic                   perr_q, perr_d;
  logic [ERR_CNT_W-1:0]   errcnt_q, errcnt_d;
  logic                   busy_q, busy_d;
  logic                   data_par;
  logic                   mismatch;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  parity_reduce #(.DATA_W(DATA_W)) u_reduce (
    .data_i   (shreg_q),
    .parity_o (data_par)
  );

  assign mismatch = data_par ^ bit_in ^ PARITY_ODD;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    dout_d   = dout_q;
    dv_d     = 1'b0;
    perr_d   = perr_q;
    errcnt_d = errcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (start) begin
          cnt_d = '0;
        end else if (bit_valid) begin
          shreg_d    = shreg_q << 1;
          shreg_d[0] = bit_in;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = ST_PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        // start wins over a coincident parity bit: the frame is dropped
        if (start) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else if (bit_valid) begin
          state_d = ST_IDLE;
          dout_d  = shreg_q;
          perr_d  = mismatch;
          dv_d    = 1'b1;
          if (mismatch) errcnt_d = sat_inc(errcnt_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      perr_q   <= 1'b0;
      errcnt_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      perr_q   <= perr_d;
      errcnt_q <= errcnt_d;
      busy_q   <= busy_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign parity_err = perr_q;
  assign err_count  = errcnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_parity_check_rx.sv
// Directed bench for parity_check_rx with a scoreboard of expected frame results.
module tb_parity_check_rx;

  localparam int DW = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
    logic [7:0]    ecnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic [7:0]    err_count;
  logic          busy;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   dv_count = 0;
  int   model_ec = 0;

  parity_check_rx #(.DATA_W(DW), .PARITY_ODD(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .err_count  (err_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Scoreboard consumer: every data_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && data_valid) begin
      dv_count++;
      if (sb.size() == 0) begin
        check("unexpected_data_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("frame_data_out", 32'(data_out), 32'(e.data));
        check("frame_parity_err", 32'(parity_err), 32'(e.perr));
        check("frame_err_count", 32'(err_count), 32'(e.ecnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    bit_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_data(input logic [DW-1:0] d);
    for (int i = DW - 1; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic p);
    exp_t e;
    e.data = d;
    e.perr = (^d) ^ p;
    if (e.perr && model_ec < 255) model_ec++;
    e.ecnt = 8'(model_ec);
    sb.push_back(e);
  endtask

  task automatic frame(input logic [DW-1:0] d, input logic p);
    do_start();
    send_data(d);
    push_exp(d, p);
    send_bit(p);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
    check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int dv_before;
    #1 rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Good even-parity frame, then a mismatch and a clean zero frame.
    frame(4'b1011, 1'b1);
    tick();
    frame(4'b1011, 1'b0);
    tick();
    frame(4'b0000, 1'b0);
    tick();

    // Gaps in bit_valid mid-frame must not disturb the result.
    do_start();
    check("gap_busy_after_start", 32'(busy), 32'd1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_busy_hold", 32'(busy), 32'd1);
    end
    send_bit(1'b1);
    send_bit(1'b0);
    push_exp(4'b0110, 1'b0);
    send_bit(1'b0);
    tick();
    check("gap_busy_done", 32'(busy), 32'd0);

    // Restart after two data bits yields exactly one pulse.
    dv_before = dv_count;
    do_start();
    send_bit(1'b1);
    send_bit(1'b0);
    frame(4'b1111, 1'b0);
    tick();
    tick();
    check("restart_single_dv", 32'(dv_count - dv_before), 32'd1);

    // start coincident with the parity bit aborts the frame.
    dv_before = dv_count;
    do_start();
    send_data(4'b1010);
    start = 1'b1;
    bit_in = 1'b1;
    bit_valid = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b0;
    send_data(4'b1100);
    push_exp(4'b1100, 1'b0);
    send_bit(1'b0);
    tick();
    tick();
    check("abort_at_parity_single_dv", 32'(dv_count - dv_before), 32'd1);

    // Back-to-back bad frames drive the counter into saturation.
    for (int n = 0; n < 260; n++) frame(4'b0000, 1'b1);
    tick();
    check("err_count_saturated", 32'(err_count), 32'd255);
    tick();
    check("err_count_holds", 32'(err_count), 32'd255);

    // Asynchronous reset mid-frame clears everything without a clock edge.
    do_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    dv_before = dv_count;
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    model_ec = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("no_dv_after_reset", 32'(dv_count - dv_before), 32'd0);
    frame(4'b1001, 1'b0);
    tick();
    tick();
    check("post_reset_frame_dv", 32'(dv_count - dv_before), 32'd1);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
